// File: rtl/alu_rr_sequencer_pkg.sv
// Shared definitions for the ALU round-robin sequencer.
// Command codes, FSM encoding and default widths.
package alu_defs;

  localparam int DW_DEF = 8;
  localparam int RW_DEF = 16;
  localparam int CW_DEF = 4;

  localparam logic [3:0] CMD_ADD = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_SHR = 4'b0111;
  localparam logic [3:0] CMD_BUF = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_rr_sequencer_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant,
// pointer advances past the winner on each accepted grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr;

  always_comb begin
    grant    = 2'b00;
    grant[0] = valid[0] & (~valid[1] | ~ptr);
    grant[1] = valid[1] & (~valid[0] | ptr);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      ptr <= 1'b0;
    else if (advance)
      ptr <= grant[0];
  end

endmodule

// File: rtl/alu_rr_sequencer.sv
// Shares one ALU between two requesters: round-robin accept,
// hold operands with oe for ALU_LAT cycles, return y to the owner.
module alu_rr_sequencer
  import alu_defs::*;
#(
  parameter int DW      = DW_DEF,
  parameter int RW      = RW_DEF,
  parameter int CW      = CW_DEF,
  parameter int ALU_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic [CW-1:0] req0_cmd,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  input  logic [CW-1:0] req1_cmd,
  output logic          rsp0_valid,
  input  logic          rsp0_ready,
  output logic          rsp1_valid,
  input  logic          rsp1_ready,
  output logic [RW-1:0] rsp_data,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [CW-1:0] alu_cmd,
  output logic          alu_oe,
  input  logic [RW-1:0] alu_y,
  output logic          busy,
  output logic [15:0]   op_count
);

  localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

  state_t          state, state_n;
  logic [1:0]      grant;
  logic [3:0]      wait_q;
  logic            owner;
  logic            acc;
  logic            done;
  logic [DW-1:0]   a_q, b_q;
  logic [CW-1:0]   cmd_q;
  logic [RW-1:0]   data_q;
  logic [15:0]     op_count_q;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   ({req1_valid, req0_valid}),
    .advance (acc),
    .grant   (grant)
  );

  assign acc  = (req0_valid & req0_ready)
              | (req1_valid & req1_ready);
  assign done = (rsp0_valid & rsp0_ready)
              | (rsp1_valid & rsp1_ready);

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (acc) state_n = EXEC;
      EXEC: if (wait_q == 4'd0) state_n = RESP;
      RESP: if (done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    alu_oe     = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    busy       = (state != IDLE);
    unique case (1'b1)
      state == IDLE: begin
        req0_ready = grant[0];
        req1_ready = grant[1];
      end
      state == EXEC: alu_oe = 1'b1;
      state == RESP: begin
        rsp0_valid = ~owner;
        rsp1_valid = owner;
      end
      default: ;
    endcase
  end

  // Operands stay latched after EXEC; only oe gates the ALU.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      cmd_q      <= '0;
      owner      <= 1'b0;
      wait_q     <= '0;
      data_q     <= '0;
      op_count_q <= '0;
    end else begin
      unique case (state)
        IDLE: if (acc) begin
          a_q    <= grant[1] ? req1_a : req0_a;
          b_q    <= grant[1] ? req1_b : req0_b;
          cmd_q  <= grant[1] ? req1_cmd : req0_cmd;
          owner  <= grant[1];
          wait_q <= LAT_M1;
        end
        EXEC: begin
          if (wait_q == 4'd0)
            data_q <= alu_y;
          else
            wait_q <= wait_q - 4'd1;
        end
        RESP: if (done) op_count_q <= op_count_q + 16'd1;
        default: ;
      endcase
    end
  end

  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_cmd  = cmd_q;
  assign rsp_data = data_q;
  assign op_count = op_count_q;

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Bench for alu_rr_sequencer: directed cases plus random traffic
// against a transaction-level model with a timing-aware ALU stub.
module tb_alu_rr_sequencer;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [7:0]  req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_cmd, req1_cmd;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [15:0] rsp_data;
  logic [7:0]  alu_a, alu_b;
  logic [3:0]  alu_cmd;
  logic        alu_oe;
  logic [15:0] alu_y;
  logic        busy;
  logic [15:0] op_count;

  always #5 clk = ~clk;

  alu_rr_sequencer #(.ALU_LAT(LAT)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cmd   (req0_cmd),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cmd   (req1_cmd),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp_data   (rsp_data),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_cmd    (alu_cmd),
    .alu_oe     (alu_oe),
    .alu_y      (alu_y),
    .busy       (busy),
    .op_count   (op_count)
  );

  function automatic logic [15:0] alu_f(
    input logic [7:0] a, input logic [7:0] b, input logic [3:0] c);
    case (c)
      4'b0000: return {8'h00, a} + {8'h00, b};
      4'b0010: return {8'h00, a} - {8'h00, b};
      4'b0111: return {8'h00, a >> b[2:0]};
      4'b1111: return {8'h00, a};
      default: return {c, 4'h0, a} ^ {8'h00, b};
    endcase
  endfunction

  // ALU stub: y is only meaningful once oe has been held LAT cycles
  int oe_run = 0;
  always @(posedge clk) oe_run <= alu_oe ? oe_run + 1 : 0;
  assign alu_y = (alu_oe && oe_run == LAT - 1)
               ? alu_f(alu_a, alu_b, alu_cmd) : 16'hDEAD;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic        m_busy, m_owner, m_ptr;
  logic [15:0] m_res, m_cnt;
  logic [7:0]  m_a, m_b;
  logic [3:0]  m_cmd;
  int          m_rsp_at;
  logic [15:0] seen0, seen1;
  int          last_g;
  logic [7:0]  d0a, d0b, d1a, d1b;
  logic [3:0]  d0c, d1c;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d",
               tag, got, exp, cyc);
    end
  endtask

  task automatic m_reset();
    m_busy = 1'b0;
    m_owner = 1'b0;
    m_ptr = 1'b0;
    m_cnt = 16'h0000;
  endtask

  task automatic step(input logic v0, input logic v1,
                      input logic r0, input logic r1,
                      input logic rn);
    logic g0, g1, ev, eoe, own_rdy;
    @(negedge clk);
    req0_valid = v0;
    req1_valid = v1;
    rsp0_ready = r0;
    rsp1_ready = r1;
    rst_n = rn;
    req0_a = d0a; req0_b = d0b; req0_cmd = d0c;
    req1_a = d1a; req1_b = d1b; req1_cmd = d1c;
    #1;
    g0 = !m_busy && v0 && (!v1 || !m_ptr);
    g1 = !m_busy && v1 && (!v0 || m_ptr);
    ev = m_busy && (cyc >= m_rsp_at);
    eoe = m_busy && !ev;
    chk("req0_ready", req0_ready, g0);
    chk("req1_ready", req1_ready, g1);
    chk("rsp0_valid", rsp0_valid, ev && !m_owner);
    chk("rsp1_valid", rsp1_valid, ev && m_owner);
    chk("alu_oe", alu_oe, eoe);
    chk("busy", busy, m_busy);
    chk("op_count", op_count, m_cnt);
    if (eoe) begin
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      chk("alu_cmd", alu_cmd, m_cmd);
    end
    if (ev) begin
      chk("rsp_data", rsp_data, m_res);
      if (m_owner) seen1 = rsp_data;
      else seen0 = rsp_data;
    end
    if (!rn) begin
      m_reset();
    end else begin
      own_rdy = m_owner ? r1 : r0;
      if (ev && own_rdy) begin
        m_busy = 1'b0;
        m_cnt = m_cnt + 16'd1;
      end
      if (g0 || g1) begin
        m_busy = 1'b1;
        m_owner = g1;
        m_a = g1 ? d1a : d0a;
        m_b = g1 ? d1b : d0b;
        m_cmd = g1 ? d1c : d0c;
        m_res = alu_f(m_a, m_b, m_cmd);
        m_rsp_at = cyc + LAT + 1;
        m_ptr = g0;
        last_g = g1 ? 1 : 0;
      end
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    d0a = 8'h00; d0b = 8'h00; d0c = 4'h0;
    d1a = 8'h00; d1b = 8'h00; d1c = 4'h0;
    req0_a = 8'h00; req0_b = 8'h00; req0_cmd = 4'h0;
    req1_a = 8'h00; req1_b = 8'h00; req1_cmd = 4'h0;
    seen0 = 16'h0; seen1 = 16'h0; last_g = -1;
    m_reset();
    repeat (2) @(posedge clk);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("rst_data", rsp_data, 16'h0000);
    chk("rst_alu_a", alu_a, 8'h00);
    chk("rst_cnt", op_count, 16'h0000);

    // single add
    d0a = 8'h0A; d0b = 8'h05; d0c = 4'b0000;
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(LAT + 2);
    chk("add_res", seen0, 16'h000F);
    chk("add_cnt", op_count, 16'h0001);

    // simultaneous pair after reset: req0 then req1
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    d0a = 8'h0A; d0b = 8'h05; d0c = 4'b0010;
    d1a = 8'h03; d1b = 8'h04; d1c = 4'b0000;
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("rr_first", last_g, 0);
    for (int i = 0; i < LAT + 2; i++)
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("rr_second", last_g, 1);
    idle(LAT + 2);
    chk("sub_res", seen0, 16'h0005);
    chk("add2_res", seen1, 16'h0007);

    // backpressure on rsp0 while req1 waits
    d0a = 8'h21; d0b = 8'h12; d0c = 4'b1111;
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < LAT + 3; i++)
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("bp_busy", busy, 1'b1);
    chk("bp_req1_rdy", req1_ready, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("bp_res", seen0, 16'h0021);
    idle(2);

    // multi-cycle shift on req1
    d1a = 8'h0A; d1b = 8'h01; d1c = 4'b0111;
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(LAT + 2);
    chk("shr_res", seen1, 16'h0005);

    // reset during EXEC aborts
    d0a = 8'h44; d0b = 8'h11; d0c = 4'b0000;
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(LAT + 2);
    chk("abort_cnt", op_count, 16'h0000);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("abort_ptr", last_g, 0);
    idle(LAT + 2);

    // counter wrap
    @(negedge clk);
    u_dut.op_count_q = 16'hFFFF;
    m_cnt = 16'hFFFF;
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(LAT + 2);
    chk("wrap", op_count, 16'h0000);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      d0a = 8'($urandom); d0b = 8'($urandom); d0c = 4'($urandom);
      d1a = 8'($urandom); d1b = 8'($urandom); d1c = 4'($urandom);
      step($urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 199) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
